// File: rtl/traffic_light.sv
// traffic_light: two-way intersection Moore FSM (NS green/yellow, EW green/yellow)
// whose phases advance on an external one-cycle tick enable.
module traffic_light #(
    parameter int NS_G_TICKS = 5,
    parameter int NS_Y_TICKS = 2,
    parameter int EW_G_TICKS = 5,
    parameter int EW_Y_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r
);
    localparam int MAX_NS = NS_G_TICKS > NS_Y_TICKS ? NS_G_TICKS : NS_Y_TICKS;
    localparam int MAX_EW = EW_G_TICKS > EW_Y_TICKS ? EW_G_TICKS : EW_Y_TICKS;
    localparam int MAX_TICKS = MAX_NS > MAX_EW ? MAX_NS : MAX_EW;
    localparam int CNT_W = $clog2(MAX_TICKS) + 1;

    typedef enum logic [1:0] {S_NS_G, S_NS_Y, S_EW_G, S_EW_Y} state_t;

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, last;

    always_comb begin
        last = state == S_NS_G ? CNT_W'(NS_G_TICKS - 1) :
               state == S_NS_Y ? CNT_W'(NS_Y_TICKS - 1) :
               state == S_EW_G ? CNT_W'(EW_G_TICKS - 1) : CNT_W'(EW_Y_TICKS - 1);
        state_n = state;
        cnt_n = cnt;
        if (tick) begin
            if (cnt == last) begin
                cnt_n = '0;
                case (state)
                    S_NS_G:  state_n = S_NS_Y;
                    S_NS_Y:  state_n = S_EW_G;
                    S_EW_G:  state_n = S_EW_Y;
                    S_EW_Y:  state_n = S_NS_G;
                    default: state_n = S_NS_G;
                endcase
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_NS_G;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end

    assign ns_g = state == S_NS_G;
    assign ns_y = state == S_NS_Y;
    assign ns_r = state == S_EW_G || state == S_EW_Y;
    assign ew_g = state == S_EW_G;
    assign ew_y = state == S_EW_Y;
    assign ew_r = state == S_NS_G || state == S_NS_Y;
endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light: scoreboard bench for two traffic_light instances (5/2/5/2 and 1/1/1/1)
// against a tick-count-modulo-period reference model.
module tb_traffic_light;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic a_ns_g, a_ns_y, a_ns_r, a_ew_g, a_ew_y, a_ew_r;
    logic b_ns_g, b_ns_y, b_ns_r, b_ew_g, b_ew_y, b_ew_r;

    int n_chk = 0;
    int n_fail = 0;
    int ticks = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    traffic_light dut_a (
        .clk(clk), .rst(rst), .tick(tick),
        .ns_g(a_ns_g), .ns_y(a_ns_y), .ns_r(a_ns_r),
        .ew_g(a_ew_g), .ew_y(a_ew_y), .ew_r(a_ew_r)
    );

    traffic_light #(.NS_G_TICKS(1), .NS_Y_TICKS(1), .EW_G_TICKS(1), .EW_Y_TICKS(1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick),
        .ns_g(b_ns_g), .ns_y(b_ns_y), .ns_r(b_ns_r),
        .ew_g(b_ew_g), .ew_y(b_ew_y), .ew_r(b_ew_r)
    );

    // Phase follows from total ticks since reset folded into one full cycle.
    function automatic logic [5:0] lamps(input int t, input int g1, input int y1, input int g2, input int y2);
        int p;
        p = t % (g1 + y1 + g2 + y2);
        if (p < g1) return 6'b100_001;
        if (p < g1 + y1) return 6'b010_001;
        if (p < g1 + y1 + g2) return 6'b001_100;
        return 6'b001_010;
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic t);
        rst = r;
        tick = t;
        @(posedge clk);
        #1;
        if (!r) ticks = 0;
        else if (t) ticks++;
        exp_q.push_back({lamps(ticks, 5, 2, 5, 2), lamps(ticks, 1, 1, 1, 1)});
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [11:0] e;
        logic [5:0] la, lb;
        la = {a_ns_g, a_ns_y, a_ns_r, a_ew_g, a_ew_y, a_ew_r};
        lb = {b_ns_g, b_ns_y, b_ns_r, b_ew_g, b_ew_y, b_ew_r};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("lamps_a", la, e[11:6]);
            check("lamps_b", lb, e[5:0]);
            n_chk++;
            if ($countones(la[5:3]) != 1 || $countones(la[2:0]) != 1 || (!la[3] && !la[0]) ||
                $countones(lb[5:3]) != 1 || $countones(lb[2:0]) != 1 || (!lb[3] && !lb[0])) begin
                n_fail++;
                $display("FAIL invariant got a=%b b=%b want one-hot per direction with a red", la, lb);
            end
        end
    end

    initial begin
        int last_rise, cyc;
        logic prev;
        @(negedge clk);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // Default timing with a tick every 5th clock; NS green should recur every 70 clocks.
        last_rise = -1;
        prev = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            step(1'b1, (i % 5) == 4);
            if (a_ns_g && !prev) begin
                if (last_rise >= 0) check("period", 6'(i - last_rise), 6'(70));
                last_rise = i;
            end
            prev = a_ns_g;
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 400; i++) step($urandom_range(0, 49) != 0, 1'($urandom_range(0, 1)));
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
